// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared encodings for the multicycle MIPS control path: FSM state codes,
// instruction opcodes, ALU-op codes (also consumed by the ALU control
// decoder), ALU operand-B and PC-source select encodings, and the packed
// control word produced by the output decoder.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // FSM state encoding; o_state exposes these codes directly.
    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_RTEX   = 4'd6;
    localparam logic [3:0] S_RTWB   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_IMMEX  = 4'd10;
    localparam logic [3:0] S_IMMWB  = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    // Supported opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    // ALU-op codes; the ALU control decoder must use the same values.
    localparam logic [2:0] ALU_OP_NONE = 3'b000;  // add
    localparam logic [2:0] ALU_OP_JUMP = 3'b001;  // subtract (beq compare)
    localparam logic [2:0] ALU_OP_RTYP = 3'b010;  // decode funct field
    localparam logic [2:0] ALU_OP_MEMR = 3'b011;  // add (address calc)
    localparam logic [2:0] ALU_OP_ANDI = 3'b100;
    localparam logic [2:0] ALU_OP_ORRI = 3'b101;
    localparam logic [2:0] ALU_OP_XORI = 3'b110;

    // ALU operand-B select.
    localparam logic [1:0] SRC_B_REG    = 2'b00;  // register B
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;  // constant 4
    localparam logic [1:0] SRC_B_IMM    = 2'b10;  // extended immediate
    localparam logic [1:0] SRC_B_BRANCH = 2'b11;  // sext immediate << 2

    // PC source select.
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_zero;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/mips_main_fsm_if.sv
// -----------------------------------------------------------------------------
// mips_main_fsm_if
// Bundle between the main control FSM and the datapath.
//   i_opcode     : IR[31:26], valid from DECODE onward
//   i_mem_ready  : memory access completes this cycle
//   o_*          : control strobes, mux selects, ALU-op, illegal flag, state
// Modports: master = control FSM side, slave = datapath side.
// -----------------------------------------------------------------------------
interface mips_main_fsm_if;
    logic [5:0] i_opcode;
    logic       i_mem_ready;
    logic       o_pc_write;
    logic       o_pc_write_cond;
    logic       o_iord;
    logic       o_mem_read;
    logic       o_mem_write;
    logic       o_ir_write;
    logic       o_mem_to_reg;
    logic       o_reg_dst;
    logic       o_reg_write;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic       o_ext_zero;
    logic [1:0] o_pc_src;
    logic [2:0] o_alu_op;
    logic       o_illegal;
    logic [3:0] o_state;

    modport master (
        input  i_opcode, i_mem_ready,
        output o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
               o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a,
               o_alu_src_b, o_ext_zero, o_pc_src, o_alu_op, o_illegal, o_state
    );

    modport slave (
        output i_opcode, i_mem_ready,
        input  o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
               o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a,
               o_alu_src_b, o_ext_zero, o_pc_src, o_alu_op, o_illegal, o_state
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// -----------------------------------------------------------------------------
// mips_ctrl_outdec
// Combinational state/opcode -> control-word decoder.
//   state  : registered FSM state
//   opcode : IR[31:26], selects the ALU-op and extension mode in IMMEX
//   rdy    : memory ready (already qualified by the wait-enable parameter)
//   rst_n  : while low, strobes are forced off and selects show FETCH values
//   ctrl   : decoded control word
// -----------------------------------------------------------------------------
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic       rdy,
    input  logic       rst_n,
    output ctrl_word_t ctrl
);

    logic [3:0] dec_state;

    // While reset is held the register may still hold a stale state; decode
    // as FETCH so the selects are deterministic.
    assign dec_state = rst_n ? state : S_FETCH;

    always_comb begin
        // NOTE: every field gets a default first so no path infers a latch.
        ctrl = '0;
        case (dec_state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.ir_write  = rdy;
                ctrl.pc_write  = rdy;
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut.
                ctrl.alu_src_b = SRC_B_BRANCH;
                ctrl.alu_op    = ALU_OP_NONE;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_OP_MEMR;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                // Held for the whole stall, not only the completing cycle.
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_RTEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_OP_RTYP;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_REG;
                ctrl.alu_op        = ALU_OP_JUMP;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_ANDI: begin
                        ctrl.alu_op   = ALU_OP_ANDI;
                        ctrl.ext_zero = 1'b1;
                    end
                    OP_ORI: begin
                        ctrl.alu_op   = ALU_OP_ORRI;
                        ctrl.ext_zero = 1'b1;
                    end
                    OP_XORI: begin
                        ctrl.alu_op   = ALU_OP_XORI;
                        ctrl.ext_zero = 1'b1;
                    end
                    default: begin
                        // ADDIU: signed add.
                        ctrl.alu_op   = ALU_OP_NONE;
                        ctrl.ext_zero = 1'b0;
                    end
                endcase
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
            end
            default: begin
                // TRAP and unused codes: everything stays off.
            end
        endcase

        if (!rst_n) begin
            ctrl.pc_write      = 1'b0;
            ctrl.pc_write_cond = 1'b0;
            ctrl.mem_read      = 1'b0;
            ctrl.mem_write     = 1'b0;
            ctrl.ir_write      = 1'b0;
            ctrl.reg_write     = 1'b0;
        end
    end

endmodule

// File: rtl/mips_main_fsm.sv
// -----------------------------------------------------------------------------
// mips_main_fsm
// Multicycle MIPS main control unit (Moore FSM): fetch, decode, execute,
// memory and writeback sequencing, memory-ready stalls, illegal-opcode trap.
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   bus      : mips_main_fsm_if.master (opcode/mem_ready in, controls out)
// Parameters:
//   MEM_WAIT_EN : 1 = FETCH/MEMRD/MEMWR wait for i_mem_ready, 0 = ignore it
//   TRAP_HALT   : 1 = stay in TRAP until reset, 0 = one TRAP cycle then FETCH
// -----------------------------------------------------------------------------
module mips_main_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit TRAP_HALT   = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mips_main_fsm_if.master bus
);

    logic [3:0] state;
    logic [3:0] state_next;
    logic       illegal;
    logic       rdy;
    ctrl_word_t ctrl;

    assign rdy = bus.i_mem_ready || !MEM_WAIT_EN;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.i_opcode)
                    OP_RTYPE:                           state_next = S_RTEX;
                    OP_LW, OP_SW:                       state_next = S_MEMADR;
                    OP_BEQ:                             state_next = S_BRANCH;
                    OP_J:                               state_next = S_JUMP;
                    OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_next = S_IMMEX;
                    default:                            state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // Opcode cannot change here since IR only loads in FETCH.
                if (bus.i_opcode == OP_LW)      state_next = S_MEMRD;
                else if (bus.i_opcode == OP_SW) state_next = S_MEMWR;
                else                            state_next = S_FETCH;
            end
            S_MEMRD:  state_next = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = rdy ? S_FETCH : S_MEMWR;
            S_RTEX:   state_next = S_RTWB;
            S_RTWB:   state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            S_IMMEX:  state_next = S_IMMWB;
            S_IMMWB:  state_next = S_FETCH;
            S_TRAP:   state_next = TRAP_HALT ? S_TRAP : S_FETCH;
            default:  state_next = S_FETCH;
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous), and state
    // registers use non-blocking assignments so all update together.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
        end else begin
            state   <= state_next;
            // Tracks TRAP residency: set on entry, held while halted.
            illegal <= (state_next == S_TRAP);
        end
    end

    mips_ctrl_outdec u_outdec (
        .state  (state),
        .opcode (bus.i_opcode),
        .rdy    (rdy),
        .rst_n  (i_rst_n),
        .ctrl   (ctrl)
    );

    assign bus.o_pc_write      = ctrl.pc_write;
    assign bus.o_pc_write_cond = ctrl.pc_write_cond;
    assign bus.o_iord          = ctrl.iord;
    assign bus.o_mem_read      = ctrl.mem_read;
    assign bus.o_mem_write     = ctrl.mem_write;
    assign bus.o_ir_write      = ctrl.ir_write;
    assign bus.o_mem_to_reg    = ctrl.mem_to_reg;
    assign bus.o_reg_dst       = ctrl.reg_dst;
    assign bus.o_reg_write     = ctrl.reg_write;
    assign bus.o_alu_src_a     = ctrl.alu_src_a;
    assign bus.o_alu_src_b     = ctrl.alu_src_b;
    assign bus.o_ext_zero      = ctrl.ext_zero;
    assign bus.o_pc_src        = ctrl.pc_src;
    assign bus.o_alu_op        = ctrl.alu_op;
    assign bus.o_illegal       = illegal;
    assign bus.o_state         = state;

endmodule
